// File: rtl/axi4_burst_ram.sv
// AXI4 slave backed by a word-wide register array.
// Write and read paths are independent FSMs that share the array.
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid && ready are both high; once valid is raised, payload holds until then.
module axi4_burst_ram #(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_BYTES  = 4,
  parameter int ID_WIDTH    = 4,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [ADDR_BYTES*8-1:0]   awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_BYTES*8-1:0]   wdata,
  input  logic [DATA_BYTES-1:0]     wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ID_WIDTH-1:0]       arid,
  input  logic [ADDR_BYTES*8-1:0]   araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [ID_WIDTH-1:0]       rid,
  output logic [DATA_BYTES*8-1:0]   rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [1:0]                dbg_w_state_o,
  output logic                      dbg_r_state_o
);
  localparam int DATA_W  = DATA_BYTES * 8;
  localparam int ADDR_W  = ADDR_BYTES * 8;
  localparam int LOG2_DB = $clog2(DATA_BYTES);
  localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Address of the following beat; WRAP stays inside the (len+1)<<size window.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                                  input logic [7:0] len, input logic [1:0] bt);
    logic [ADDR_W-1:0] step, wmask;
    step  = ADDR_W'(1) << sz;
    wmask = ((ADDR_W'(len) + ADDR_W'(1)) << sz) - ADDR_W'(1);
    case (bt)
      2'b01:   next_addr = a + step;
      2'b10:   next_addr = (a & ~wmask) | ((a + step) & wmask);
      default: next_addr = a;
    endcase
  endfunction

  // Errors that poison every beat of a burst.
  function automatic logic burst_err(input logic [2:0] sz, input logic [7:0] len, input logic [1:0] bt);
    burst_err = (sz > 3'(LOG2_DB)) || (bt == 2'b11) ||
                ((bt == 2'b10) && !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

  function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
    addr_oob = (a >> LOG2_DB) >= ADDR_W'(DEPTH_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    word_idx = a[LOG2_DB +: IDX_W];
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic              init_q;

  w_state_e          w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]        aw_len_q, aw_len_d, w_beat_q, w_beat_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic [1:0]        aw_burst_q, aw_burst_d;
  logic              w_err_q, w_err_d;
  logic              mem_we, w_burst_err, w_oob, w_is_last;
  logic [IDX_W-1:0]  w_idx;

  r_state_e          r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] ar_id_q, ar_id_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d, r_src_addr;
  logic [7:0]        ar_len_q, ar_len_d, r_beat_q, r_beat_d, r_src_len;
  logic [2:0]        ar_size_q, ar_size_d, r_src_size;
  logic [1:0]        ar_burst_q, ar_burst_d, r_src_burst, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, r_word;
  logic [IDX_W-1:0]  r_idx;
  logic              r_load, r_src_err, r_last_beat;

  assign w_idx         = word_idx(aw_addr_q);
  assign bid           = aw_id_q;
  assign bresp         = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign rid           = ar_id_q;
  assign rdata         = rdata_q;
  assign rresp         = rresp_q;
  assign dbg_w_state_o = w_state_q;
  assign dbg_r_state_o = r_state_q;

  // Hold both address channels off for the first edge after reset releases.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  // Write FSM: next state, channel readies and the memory write enable.
  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_beat_d   = w_beat_q;
    w_err_d    = w_err_q;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    mem_we     = 1'b0;
    w_burst_err = burst_err(aw_size_q, aw_len_q, aw_burst_q);
    w_oob       = addr_oob(aw_addr_q);
    w_is_last   = (w_beat_q == aw_len_q);
    case (w_state_q)
      W_IDLE: begin
        awready = init_q;
        if (awvalid && init_q) begin
          aw_id_d    = awid;
          aw_addr_d  = awaddr;
          aw_len_d   = awlen;
          aw_size_d  = awsize;
          aw_burst_d = awburst;
          w_beat_d   = 8'd0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we    = !w_burst_err && !w_oob;
          w_err_d   = w_err_q | w_burst_err | w_oob | (wlast != w_is_last);
          aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q);
          w_beat_d  = w_beat_q + 8'd1;
          if (w_is_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: picks the next beat's address and loads its data/response.
  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_beat_d   = r_beat_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rlast      = 1'b0;
    r_load     = 1'b0;
    r_last_beat = (r_beat_q == ar_len_q);
    if (r_state_q == R_IDLE) begin
      r_src_addr  = araddr;
      r_src_len   = arlen;
      r_src_size  = arsize;
      r_src_burst = arburst;
    end else begin
      r_src_addr  = next_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);
      r_src_len   = ar_len_q;
      r_src_size  = ar_size_q;
      r_src_burst = ar_burst_q;
    end
    r_idx     = word_idx(r_src_addr);
    r_src_err = burst_err(r_src_size, r_src_len, r_src_burst) || addr_oob(r_src_addr);
    r_word    = mem_q[r_idx];
    // A write landing on the same edge is forwarded so later beats see it.
    if (mem_we && (w_idx == r_idx)) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (wstrb[b]) r_word[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
    case (r_state_q)
      R_IDLE: begin
        arready = init_q;
        if (arvalid && init_q) begin
          r_load     = 1'b1;
          ar_id_d    = arid;
          ar_len_d   = arlen;
          ar_size_d  = arsize;
          ar_burst_d = arburst;
          r_beat_d   = 8'd0;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = r_last_beat;
        if (rready) begin
          if (r_last_beat) begin
            r_state_d = R_IDLE;
          end else begin
            r_load   = 1'b1;
            r_beat_d = r_beat_q + 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      ar_addr_d = r_src_addr;
      rdata_d   = r_src_err ? '0 : r_word;
      rresp_d   = r_src_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // State and burst-context registers for both paths.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_beat_q   <= '0;
      w_err_q    <= 1'b0;
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_beat_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_beat_q   <= w_beat_d;
      w_err_q    <= w_err_d;
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_beat_q   <= r_beat_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (wstrb[b]) mem_q[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi4_burst_ram.sv
// Bench for axi4_burst_ram: directed scenarios plus randomized bursts,
// checked against a byte-level memory model with per-beat address rules.
module tb_axi4_burst_ram;
  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp, dbg_w_state;
  logic [3:0]  wstrb;
  logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rlast, rvalid, rready = 0, dbg_r_state;

  axi4_burst_ram #(.DATA_BYTES(4), .ADDR_BYTES(4), .ID_WIDTH(4), .DEPTH_WORDS(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dbg_w_state_o(dbg_w_state), .dbg_r_state_o(dbg_r_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd_a [256];
  logic [3:0]  ws_a [256];
  logic [31:0] exp_q [$];
  logic [1:0]  resp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic bad_burst(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic out_of_range(input logic [31:0] a);
    return (a / 4) >= 32'(DEPTH);
  endfunction

  // Byte address of beat i, from the burst type rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst, input int i);
    logic [31:0] step, total, base;
    step  = 32'd1 << size;
    total = (32'(len) + 32'd1) * step;
    base  = (a / total) * total;
    case (burst)
      2'b00:   return a;
      2'b10:   return base + ((a - base + 32'(i) * step) % total);
      default: return a + 32'(i) * step;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    areset = 1'b1;
    awvalid = 0; wvalid = 0; wlast = 0; arvalid = 0; bready = 0; rready = 0;
    #1;
    check_eq("rst_ctl", {awready, wready, bvalid, arready, rvalid, rlast}, 64'd0);
    check_eq("rst_dat", {bid, bresp, rid, rresp, rdata}, 64'd0);
    @(negedge aclk);
    check_eq("rst_hold", {awready, wready, bvalid, arready, rvalid, rlast}, 64'd0);
    areset = 1'b0;
    #1;
    check_eq("rst_rel", {awready, arready}, 64'd0);
    @(negedge aclk);
    check_eq("rdy_after_rst", {awready, arready, bvalid, rvalid}, 64'b1100);
  endtask

  // last_at >= 0 raises wlast on that beat only; rst_at >= 0 pulses reset
  // while that beat is offered.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int last_at, input int rst_at);
    logic bad, err;
    logic [31:0] a;
    int cnt;
    bad = bad_burst(size, len, burst);
    err = bad;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin @(negedge aclk); cnt++; end
    check_eq("aw_ready", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd_a[i]; wstrb = ws_a[i]; wvalid = 1'b1;
      wlast = (last_at >= 0) ? (i == last_at) : (i == int'(len));
      if (i == rst_at) begin
        pulse_reset();
        return;
      end
      if (i == 0) check_eq("wready_lat", wready, 1);
      cnt = 0;
      while (!wready && cnt < 50) begin @(negedge aclk); cnt++; end
      check_eq("w_ready", wready, 1);
      a = beat_addr(addr, size, len, burst, i);
      if (wlast != (i == int'(len))) err = 1'b1;
      if (!bad) begin
        if (out_of_range(a)) err = 1'b1;
        else for (int b = 0; b < 4; b++) if (ws_a[i][b]) ref_mem[a[11:2]][b*8 +: 8] = wd_a[i][b*8 +: 8];
      end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_eq("bvalid_lat", {bvalid, bid, bresp}, {1'b1, id, (err ? 2'b10 : 2'b00)});
    repeat ($urandom_range(0, 2)) begin
      @(negedge aclk);
      check_eq("b_hold", {bvalid, bid, bresp}, {1'b1, id, (err ? 2'b10 : 2'b00)});
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check_eq("b_done", {bvalid, awready}, 64'b01);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall_beat, input int stall_len);
    logic bad;
    logic [31:0] a, ed;
    logic [1:0] er;
    int cnt;
    bad = bad_burst(size, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, len, burst, i);
      if (bad || out_of_range(a)) begin exp_q.push_back(32'd0); resp_q.push_back(2'b10); end
      else begin exp_q.push_back(ref_mem[a[11:2]]); resp_q.push_back(2'b00); end
    end
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 50) begin @(negedge aclk); cnt++; end
    check_eq("ar_ready", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    check_eq("rvalid_lat", rvalid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        repeat (stall_len) begin
          @(negedge aclk);
          check_eq("r_stall", {rvalid, rlast, rresp, rdata}, {1'b1, (i == int'(len)), resp_q[0], exp_q[0]});
        end
      end
      rready = 1'b1;
      cnt = 0;
      while (!rvalid && cnt < 50) begin @(negedge aclk); cnt++; end
      ed = exp_q.pop_front();
      er = resp_q.pop_front();
      check_eq("r_beat", {rvalid, rid, rresp, rlast, rdata}, {1'b1, id, er, (i == int'(len)), ed});
      @(negedge aclk);
      rready = 1'b0;
    end
    check_eq("r_end", {rvalid, arready}, 64'b01);
  endtask

  task automatic fill_rand(input logic full_strb);
    for (int i = 0; i < 256; i++) begin
      wd_a[i] = $urandom;
      ws_a[i] = full_strb ? 4'hF : 4'($urandom_range(0, 15));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int r, last_at;

    @(negedge aclk);
    pulse_reset();

    // Give every word a known value.
    for (int k = 0; k < 4; k++) begin
      fill_rand(1'b1);
      do_write(4'(k), 32'(k * 1024), 8'd255, 3'd2, 2'b01, -1, -1);
    end

    // INCR write / read, then WRAP read over the same words.
    for (int i = 0; i < 4; i++) begin wd_a[i] = 32'hA0 + 32'(i); ws_a[i] = 4'hF; end
    do_write(4'h1, 32'h10, 8'd3, 3'd2, 2'b01, -1, -1);
    do_read(4'h2, 32'h10, 8'd3, 3'd2, 2'b01, -1, 0);
    do_read(4'h3, 32'h18, 8'd3, 3'd2, 2'b10, -1, 0);

    // Byte strobes, then FIXED burst overwriting one word.
    wd_a[0] = 32'h11223344; ws_a[0] = 4'hF;
    do_write(4'h4, 32'h0, 8'd0, 3'd2, 2'b01, -1, -1);
    wd_a[0] = 32'hFFFFFFFF; ws_a[0] = 4'h2;
    do_write(4'h5, 32'h0, 8'd0, 3'd2, 2'b01, -1, -1);
    do_read(4'h6, 32'h0, 8'd0, 3'd2, 2'b01, -1, 0);
    for (int i = 0; i < 3; i++) begin wd_a[i] = 32'(i + 1); ws_a[i] = 4'hF; end
    do_write(4'h7, 32'h4, 8'd2, 3'd2, 2'b00, -1, -1);
    do_read(4'h8, 32'h4, 8'd0, 3'd2, 2'b01, -1, 0);

    // Running off the end, reserved burst type.
    do_read(4'h9, 32'((DEPTH - 1) * 4), 8'd1, 3'd2, 2'b01, -1, 0);
    fill_rand(1'b1);
    do_write(4'hA, 32'h20, 8'd1, 3'd2, 2'b11, -1, -1);
    do_read(4'hB, 32'h20, 8'd1, 3'd2, 2'b01, -1, 0);

    // Early wlast, then a long rready stall.
    fill_rand(1'b1);
    do_write(4'hC, 32'h40, 8'd3, 3'd2, 2'b01, 1, -1);
    do_read(4'hD, 32'h40, 8'd3, 3'd2, 2'b01, 1, 5);

    // Reset in the middle of a write burst.
    fill_rand(1'b1);
    do_write(4'hE, 32'h80, 8'd7, 3'd2, 2'b01, -1, 2);
    do_read(4'hF, 32'h80, 8'd7, 3'd2, 2'b01, -1, 0);

    // Randomized bursts.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      size = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : (r == 2) ? 3'($urandom_range(3, 7)) : 3'd2;
      r = $urandom_range(0, 9);
      burst = (r < 2) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if (burst == 2'b10) begin
        r = $urandom_range(0, 4);
        len = (r == 4) ? 8'd2 : 8'((2 << r) - 1);
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      r = $urandom_range(0, 9);
      if (r == 0)      addr = 32'(DEPTH * 4 - 4 * $urandom_range(1, 4));
      else if (r == 1) addr = 32'(DEPTH * 4 + $urandom_range(0, 255));
      else             addr = 32'($urandom_range(0, DEPTH * 4 - 1));
      addr = addr & ~((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 1) == 0) begin
        fill_rand($urandom_range(0, 2) != 0);
        last_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(len))) : -1;
        do_write(4'($urandom), addr, len, size, burst, last_at, -1);
      end else begin
        do_read(4'($urandom), addr, len, size, burst, int'($urandom_range(0, int'(len))),
                int'($urandom_range(0, 3)));
      end
    end

    // Concurrent write and read on disjoint halves of the memory.
    for (int n = 0; n < 10; n++) begin
      fill_rand(1'b0);
      fork
        do_write(4'($urandom), 32'($urandom_range(0, 16'h700)) & ~32'd3, 8'($urandom_range(0, 15)),
                 3'd2, 2'b01, -1, -1);
        do_read(4'($urandom), 32'($urandom_range(16'h800, 16'hF00)) & ~32'd3, 8'($urandom_range(0, 15)),
                3'd2, 2'b01, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      join
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if a handshake never resolves.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete (vectors %0d)", n_vec);
    $fatal(1);
  end
endmodule

// File: doc/axi4_burst_ram.md
# axi4_burst_ram

AXI4 full-protocol slave backed by an internal register-array memory, the burst-capable successor to the bus's AXI3-style channel definition. Generalises IDs, burst length (8-bit AWLEN/ARLEN), and adds FIXED/INCR/WRAP bursts, narrow transfers, byte strobes and error responses. Serves as a bench memory model and a small on-chip scratchpad behind the interconnect. Write and read paths are independent state machines sharing one memory array.

## Interface
- DATA_BYTES, 4, data bus width in bytes (power of two, 1..128)
- ADDR_BYTES, 4, address width in bytes
- ID_WIDTH, 4, width of all ID fields
- DEPTH_WORDS, 1024, memory depth in DATA_BYTES-wide words
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_BYTES*8/8/3/2  write address fields
- awvalid  in  1, awready  out  1  AW handshake
- wdata/wstrb/wlast  in  DATA_BYTES*8/DATA_BYTES/1  write data fields
- wvalid  in  1, wready  out  1  W handshake
- bid/bresp  out  ID_WIDTH/2, bvalid  out  1, bready  in  1  write response
- arid/araddr/arlen/arsize/arburst  in  as AW  read address fields
- arvalid  in  1, arready  out  1  AR handshake
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_BYTES*8/2/1, rvalid  out  1, rready  in  1  read data

## Operation
- Write FSM: W_IDLE (awready=1) -> W_DATA on AW handshake (latch id, addr, len, size, burst, clear beat count and error flag) -> W_RESP after beat len accepted -> W_IDLE on B handshake.
- Read FSM: R_IDLE (arready=1) -> R_DATA on AR handshake -> R_IDLE on handshake of beat len (rlast=1).
- Word index = addr >> log2(DATA_BYTES); byte lanes written where wstrb bit set; wstrb passed as-is for narrow beats.
- Next address: FIXED unchanged; INCR addr + (1<<size); WRAP addr + (1<<size) wrapped within (len+1)<<size aligned window.
- SLVERR (2'b10) conditions: size > log2(DATA_BYTES); burst 2'b11; WRAP with len not in {1,3,7,15}; word index >= DEPTH_WORDS (per beat); wlast not matching beat==len.
- Burst-level errors (size, burst, wrap len): all writes suppressed, all read beats rdata=0, rresp=SLVERR, full beat count still exchanged.
- Per-beat out-of-range: that write suppressed; that read beat rdata=0, rresp=SLVERR; other beats OKAY.
- bresp: sticky OR of any error in the burst; OKAY (2'b00) otherwise. bid/rid echo latched id.
- Burst always ends after len+1 beats, independent of wlast.

## Timing
- During areset and in the first edge after: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0. awready/arready rise the first cycle after reset deasserts.
- Memory contents not reset; reset mid-burst returns both FSMs to IDLE, beats already written remain.
- AW handshake cycle N -> wready=1 from N+1; one beat per cycle while wvalid.
- Last W beat accepted cycle M -> bvalid=1 at M+1, held with stable bid/bresp until bready.
- awready=1 the cycle after B handshake (one bubble between write bursts).
- AR handshake cycle N -> rvalid=1 at N+1 with beat 0; next beat the cycle after each R handshake; rdata/rresp/rlast stable while rvalid && !rready.
- arready=1 the cycle after final R handshake.
- Simultaneous write and read to same word: read beat presented that cycle shows pre-write contents; following beats see new data.
- awready/arready never depend on the other channel; both bursts may run concurrently.

## Test plan
- INCR write len=3, size=2, addr 0x10, data 0xA0..0xA3, wstrb 0xF -> bresp OKAY, bvalid one cycle after 4th beat; INCR read same -> 0xA0..0xA3, rlast on beat 3.
- WRAP read len=3, size=2, addr 0x18 after above -> data 0xA2, 0xA3, 0xA0, 0xA1.
- Write 0x11223344 to 0x0, then wstrb 0x2 with 0xFFFFFFFF -> read 0x1122FF44; FIXED write len=2 to 0x4 data 1,2,3 -> read 0x4 returns 3.
- INCR read len=1 starting at last word (DEPTH_WORDS-1) -> beat0 OKAY, beat1 rdata 0 SLVERR; awburst=2'b11 write len=1 -> no memory change, bresp SLVERR.
- wlast asserted on beat 1 of len=3 write -> 4 beats accepted, bresp SLVERR; rready held low 5 cycles mid-burst -> rdata stable throughout.
- areset pulsed during beat 2 of len=7 write -> all valids/readies 0, awready=1 next cycle, beats 0-1 readable with written data.
